// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : two-port round-robin arbiter sharing one combinational ALU,
//               with a one-entry registered response returned to the owner.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [WIDTH-1:0]  req0_op1,
   input  logic [WIDTH-1:0]  req0_op2,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [WIDTH-1:0]  req1_op1,
   input  logic [WIDTH-1:0]  req1_op2,
   input  logic [CTRL_W-1:0] req1_ctrl,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [WIDTH-1:0]  rsp_result,
   output logic              rsp_zero,
   output logic [WIDTH-1:0]  alu_op1,
   output logic [WIDTH-1:0]  alu_op2,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_zero
);

   logic             r_busy;
   logic             r_owner;
   logic             r_last;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;

   logic w_drain;
   logic w_can_accept;
   logic w_grant;
   logic w_winner;

   // Only the owner's rsp_ready can free the register; the other port's is ignored.
   assign w_drain      = r_busy && (r_owner ? rsp1_ready : rsp0_ready);
   assign w_can_accept = !r_busy || w_drain;
   assign w_winner     = (req0_valid && req1_valid) ? !r_last : req1_valid;
   assign w_grant      = w_can_accept && (req0_valid || req1_valid);

   assign req0_ready = w_grant && !w_winner;
   assign req1_ready = w_grant &&  w_winner;

   always_comb begin
      alu_op1  = '0;
      alu_op2  = '0;
      alu_ctrl = '0;
      if (w_grant) begin
         alu_op1  = w_winner ? req1_op1  : req0_op1;
         alu_op2  = w_winner ? req1_op2  : req0_op2;
         alu_ctrl = w_winner ? req1_ctrl : req0_ctrl;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_owner  <= 1'b0;
         r_last   <= 1'b1;
         r_result <= '0;
         r_zero   <= 1'b0;
      end else if (w_grant) begin
         r_busy   <= 1'b1;
         r_owner  <= w_winner;
         r_last   <= w_winner;
         r_result <= alu_result;
         r_zero   <= alu_zero;
      end else if (w_drain) begin
         r_busy   <= 1'b0;
      end
   end

   assign rsp0_valid = r_busy && !r_owner;
   assign rsp1_valid = r_busy &&  r_owner;
   assign rsp_result = r_result;
   assign rsp_zero   = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter : directed self-checking bench for alu_arbiter with an RV32I
//                  ALU stub attached to the shared ALU port.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

   localparam int WIDTH  = 32;
   localparam int CTRL_W = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_valid, req1_valid;
   logic              req0_ready, req1_ready;
   logic [WIDTH-1:0]  req0_op1, req0_op2, req1_op1, req1_op2;
   logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
   logic              rsp0_valid, rsp1_valid;
   logic              rsp0_ready, rsp1_ready;
   logic [WIDTH-1:0]  rsp_result;
   logic              rsp_zero;
   logic [WIDTH-1:0]  alu_op1, alu_op2;
   logic [CTRL_W-1:0] alu_ctrl;
   logic [WIDTH-1:0]  alu_result;
   logic              alu_zero;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   // RV32I func3 ALU stub standing in for the real ALU instance
   always_comb begin
      case (alu_ctrl)
         3'b000:  alu_result = alu_op1 + alu_op2;
         3'b001:  alu_result = alu_op1 << alu_op2[4:0];
         3'b010:  alu_result = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
         3'b011:  alu_result = {31'd0, alu_op1 < alu_op2};
         3'b100:  alu_result = alu_op1 ^ alu_op2;
         3'b101:  alu_result = alu_op1 >> alu_op2[4:0];
         3'b110:  alu_result = alu_op1 | alu_op2;
         default: alu_result = alu_op1 & alu_op2;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 0; req1_valid = 0;
      req0_op1 = 0; req0_op2 = 0; req0_ctrl = 0;
      req1_op1 = 0; req1_op2 = 0; req1_ctrl = 0;
      rsp0_ready = 0; rsp1_ready = 0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("reset rsp0_valid", 32'(rsp0_valid), 0);
      chk("reset rsp1_valid", 32'(rsp1_valid), 0);
      chk("reset rsp_result", rsp_result, 0);
      chk("reset rsp_zero",   32'(rsp_zero), 0);
      chk("reset req0_ready", 32'(req0_ready), 0);
      chk("reset alu_op1",    alu_op1, 0);

      // contention straight after reset: port 0 first, then strict alternation
      req0_valid = 1; req0_op1 = 3; req0_op2 = 4; req0_ctrl = 3'b000;
      req1_valid = 1; req1_op1 = 32'hF0F0F0F0; req1_op2 = 32'h0F0F0F0F; req1_ctrl = 3'b111;
      rsp0_ready = 1; rsp1_ready = 1;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("contend%0d req0_ready", k), 32'(req0_ready), 32'(k % 2 == 0));
         chk($sformatf("contend%0d req1_ready", k), 32'(req1_ready), 32'(k % 2 == 1));
         step();
         chk($sformatf("contend%0d rsp0_valid", k), 32'(rsp0_valid), 32'(k % 2 == 0));
         chk($sformatf("contend%0d result", k), rsp_result, (k % 2 == 0) ? 32'd7 : 32'd0);
         chk($sformatf("contend%0d zero", k), 32'(rsp_zero), 32'(k % 2 == 1));
      end
      req0_valid = 0; req1_valid = 0;
      step();
      chk("contend drained", 32'(rsp1_valid), 0);

      // single op, no contention
      req0_valid = 1; req0_op1 = 5; req0_op2 = 7; req0_ctrl = 3'b000;
      #1;
      chk("single req0_ready", 32'(req0_ready), 1);
      chk("single alu_op2", alu_op2, 7);
      step();
      req0_valid = 0;
      chk("single rsp0_valid", 32'(rsp0_valid), 1);
      chk("single result", rsp_result, 12);
      chk("single zero", 32'(rsp_zero), 0);
      chk("single rsp1_valid", 32'(rsp1_valid), 0);
      step();
      chk("single drained", 32'(rsp0_valid), 0);

      // backpressure on port 0 while port 1 waits
      rsp0_ready = 0;
      req0_valid = 1; req0_op1 = 32'hA5A5A5A5; req0_op2 = 32'hFFFFFFFF; req0_ctrl = 3'b100;
      #1;
      chk("bp req0_ready", 32'(req0_ready), 1);
      step();
      req0_valid = 0;
      req1_valid = 1; req1_op1 = 1; req1_op2 = 1; req1_ctrl = 3'b000;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp%0d req1_ready", k), 32'(req1_ready), 0);
         chk($sformatf("bp%0d result", k), rsp_result, 32'h5A5A5A5A);
         chk($sformatf("bp%0d rsp0_valid", k), 32'(rsp0_valid), 1);
         step();
      end
      rsp0_ready = 1;
      #1;
      chk("bp release req1_ready", 32'(req1_ready), 1);
      step();
      req1_valid = 0;
      chk("bp rsp1_valid", 32'(rsp1_valid), 1);
      chk("bp rsp0_valid", 32'(rsp0_valid), 0);
      chk("bp port1 result", rsp_result, 2);
      step();

      // back-to-back chaining on port 1
      req1_valid = 1; req1_op1 = 32'hFFFFFFFF; req1_op2 = 1; req1_ctrl = 3'b010;
      #1;
      chk("chain slt ready", 32'(req1_ready), 1);
      step();
      req1_ctrl = 3'b011;
      #1;
      chk("chain sltu ready", 32'(req1_ready), 1);
      chk("chain slt result", rsp_result, 1);
      chk("chain slt zero", 32'(rsp_zero), 0);
      chk("chain slt valid", 32'(rsp1_valid), 1);
      step();
      req1_valid = 0;
      chk("chain sltu result", rsp_result, 0);
      chk("chain sltu zero", 32'(rsp_zero), 1);
      chk("chain sltu valid", 32'(rsp1_valid), 1);
      step();

      // non-owner rsp_ready must not drain port 0's response
      rsp0_ready = 0; rsp1_ready = 1;
      req0_valid = 1; req0_op1 = 5; req0_op2 = 7; req0_ctrl = 3'b000;
      step();
      req0_valid = 0;
      req1_valid = 1; req1_op1 = 9; req1_op2 = 9; req1_ctrl = 3'b000;
      step(); step();
      chk("ignored rsp0_valid", 32'(rsp0_valid), 1);
      chk("ignored result", rsp_result, 12);
      chk("ignored req1_ready", 32'(req1_ready), 0);

      // reset while busy discards the response and restores port-0 priority
      req1_valid = 0;
      rst = 1;
      step();
      rst = 0;
      chk("rst mid rsp0_valid", 32'(rsp0_valid), 0);
      chk("rst mid rsp1_valid", 32'(rsp1_valid), 0);
      chk("rst mid result", rsp_result, 0);
      chk("rst mid zero", 32'(rsp_zero), 0);
      req0_valid = 1; req0_op1 = 3; req0_op2 = 4; req0_ctrl = 3'b000;
      req1_valid = 1; req1_op1 = 1; req1_op2 = 1; req1_ctrl = 3'b000;
      rsp0_ready = 1;
      #1;
      chk("post rst req0_ready", 32'(req0_ready), 1);
      chk("post rst req1_ready", 32'(req1_ready), 0);
      step();
      req0_valid = 0; req1_valid = 0;
      chk("post rst rsp0_valid", 32'(rsp0_valid), 1);
      chk("post rst result", rsp_result, 7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter that shares the single combinational RV32I ALU between two requesters: port 0, the execute stage, and port 1, the branch/compare or address-generation path. It drives the ALU operand and control inputs from the granted requester. It captures the ALU result and zero flag into a one-entry response register. It returns the response to the owning requester over a valid/ready handshake. It sits between the requesters and the ALU instance.

## Interface
Parameters:
- WIDTH, 32: operand and result width
- CTRL_W, 3: ALU control width (func3 encoding)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- req0_valid / req1_valid  in  1  request present on port i
- req0_ready / req1_ready  out  1  request on port i accepted this cycle
- req0_op1, req0_op2 / req1_op1, req1_op2  in  WIDTH  operands
- req0_ctrl / req1_ctrl  in  CTRL_W  ALU control for the request
- rsp0_valid / rsp1_valid  out  1  response for port i held in the register
- rsp0_ready / rsp1_ready  in  1  port i consumes its response
- rsp_result  out  WIDTH  registered ALU result, shared by both ports
- rsp_zero  out  1  registered zero flag
- alu_op1, alu_op2  out  WIDTH  to the ALU
- alu_ctrl  out  CTRL_W  to the ALU
- alu_result  in  WIDTH  from the ALU
- alu_zero  in  1  from the ALU

## Operation
- State:
  - busy: response register occupied
  - owner: 1 bit, port that owns the response
  - last: 1 bit, last granted port
  - result and zero registers
- rsp_i_valid = busy && owner==i.
- Drain: drain = busy && rsp_{owner}_ready.
- Accept: can_accept = !busy || drain. Dependent requesters may chain at full throughput.
- Arbitration, evaluated only when can_accept is high:
  - Only one req_valid high: that port wins.
  - Both high: port !last wins.
  - Neither high: no grant.
- Ready signals:
  - req_i_ready = can_accept && winner==i.
  - ready may depend combinationally on req_valid. Requesters must not make valid depend on ready.
- ALU drive:
  - On grant, alu_op1/op2/ctrl = the winner's fields.
  - With no grant, all three are driven to 0.
- On accept (valid && ready):
  - result <= alu_result, zero <= alu_zero
  - owner <= winner, last <= winner, busy <= 1
- Drain without accept: busy <= 0. result, zero and owner hold their values.
- Drain and accept in the same cycle: the new response overwrites. busy stays 1.
- While busy && !rsp_{owner}_ready:
  - no accepts
  - rsp_result, rsp_zero and rsp_i_valid are held stable
- The non-owner's rsp_ready is ignored.
- No width transformation: result and zero pass through the ALU unmodified. All arithmetic rules belong to the ALU.

## Timing
- Reset values:
  - busy=0, owner=0, result=0, zero=0
  - last=1, so port 0 wins the first contention
  - Every output is therefore 0 in the cycle after reset.
- Latency: request accepted at edge N produces rsp_valid from cycle N+1.
- Throughput: one operation per cycle when the owner asserts rsp_ready continuously.
- Fairness: under continuous contention with responses always drained, grants alternate 0,1,0,1.
- Worst-case wait for a valid requester: one grant to the other port, plus that port's drain time.
- Reset mid-operation: rst asserted while busy discards the pending response. No rsp_valid appears in the cycle after rst is released.
- The requester must hold req fields stable from valid until ready.
- No combinational path from rsp_ready to rsp_result.

## Test plan
- Single op, no contention:
  - stimulus: req0 op1=5, op2=7, ctrl=000
  - expected: req0_ready=1 the same cycle; next cycle rsp0_valid=1, rsp_result=12, rsp_zero=0, rsp1_valid=0
- Contention right after reset:
  - stimulus: both ports valid; port 0 add 3+4, port 1 and 0xF0F0F0F0 & 0x0F0F0F0F (ctrl=111); both rsp_ready=1
  - expected: port 0 granted first (result 7); port 1 next cycle (result 0, zero=1); then alternation continues for 6 cycles
- Backpressure:
  - stimulus: port 0 xor 0xA5A5A5A5^0xFFFFFFFF with rsp0_ready=0 for 3 cycles; port 1 valid throughout
  - expected: rsp_result=0x5A5A5A5A held, req1_ready=0 for 3 cycles; port 1 granted in the cycle rsp0_ready rises
- Back-to-back chaining:
  - stimulus: port 1 issues slt 0xFFFFFFFF<1 (ctrl=010), then sltu with the same operands (ctrl=011), rsp1_ready=1
  - expected: results 1 then 0 on consecutive cycles, rsp1_valid continuously high, zero=0 then 1
- Ignored ready:
  - stimulus: owner=0, rsp0_ready=0, rsp1_ready=1
  - expected: response held; no drain
- Reset mid-operation:
  - stimulus: rst high for one cycle while busy with result 12
  - expected: all outputs 0 next cycle; first post-reset contention grants port 0
